// File: rtl/systolic_array_ctrl_if.sv
// Tile command handshake between the command source and the systolic array sequencer.
interface systolic_array_ctrl_if #(
   parameter int LEN_W = 10
) ();
   logic             valid;
   logic             ready;
   logic [LEN_W-1:0] len;
   logic             last;

   modport master (output valid, output len, output last, input ready);
   modport slave  (input valid, input len, input last, output ready);
endinterface

// File: rtl/systolic_array_ctrl.sv
// Weight-stationary systolic array sequencer: double-buffered weight loads,
// activation streaming, diagonal bank-select wavefront and result tagging.
module systolic_array_ctrl #(
   parameter int MUL_SIZE = 8,
   parameter int LEN_W    = 10,
   parameter int PIPE_LAT = 2*MUL_SIZE
) (
   input  logic                               clk_i,
   input  logic                               rst_ni,
   systolic_array_ctrl_if.slave               cmd,
   output logic                               weight_rd_o,
   input  logic                               act_rdy_i,
   output logic                               act_rd_o,
   input  logic                               stall_i,
   output logic [MUL_SIZE-1:0]                load_weights_o,
   output logic                               compute_o,
   output logic                               load_activations_o,
   output logic                               stall_o,
   output logic [MUL_SIZE-1:0][MUL_SIZE-1:0]  compute_weight_sel_o,
   output logic                               result_valid_o,
   output logic                               tile_done_o,
   output logic                               busy_o
);

   localparam int CNT_W = (MUL_SIZE > 1) ? $clog2(MUL_SIZE) : 1;
   localparam int DRN_W = $clog2(PIPE_LAT + 1);
   localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(MUL_SIZE - 1);
   localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(PIPE_LAT - 1);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

   state_t              state_reg, state_next;
   logic                rdy_en_reg;
   logic [LEN_W-1:0]    pend_len_reg;
   logic                pend_last_reg;
   logic                cur_last_reg;
   logic [LEN_W-1:0]    rem_reg;
   logic                load_active_reg;
   logic [CNT_W-1:0]    load_cnt_reg;
   logic                ld_d_valid_reg;
   logic [CNT_W-1:0]    ld_d_cnt_reg;
   logic                shadow_full_reg;
   logic                first_pending_reg;
   logic [MUL_SIZE-1:0] sel_reg;
   logic                cmp_reg;
   logic                cmp_last_reg;
   logic [PIPE_LAT-1:0] res_sr_reg;
   logic [PIPE_LAT-1:0] last_sr_reg;
   logic [DRN_W-1:0]    drain_cnt_reg;
   logic                stall_reg;

   logic             load_busy, load_finish, shadow_ready, swap;
   logic [LEN_W-1:0] pend_len_eff, rem_eff;
   logic             act_rd, act_last, wave_start, wave_done, ready_int, accept;

   assign load_busy    = load_active_reg | ld_d_valid_reg;
   assign load_finish  = ld_d_valid_reg & (ld_d_cnt_reg == LOAD_LAST) & ~stall_i;
   assign shadow_ready = shadow_full_reg | load_finish;
   // A bank swap opens the next tile: from LOAD, or when the running tile has issued all reads.
   assign swap = ~stall_i & shadow_ready &
                 ((state_reg == LOAD) | ((state_reg == RUN) & (rem_reg == '0)));

   assign pend_len_eff = (pend_len_reg == '0) ? LEN_W'(1) : pend_len_reg;
   assign rem_eff      = swap ? pend_len_eff : rem_reg;
   assign act_rd       = (swap | (state_reg == RUN)) & act_rdy_i & ~stall_i & (rem_eff != '0);
   assign act_last     = (rem_eff == LEN_W'(1));
   assign wave_start   = act_rd & (swap | first_pending_reg);

   // Rows agree again once the wavefront has reached the bottom row.
   assign wave_done = ~first_pending_reg & ((&sel_reg) | ~(|sel_reg));
   assign ready_int = rdy_en_reg & ~stall_i & ~shadow_full_reg & ~load_busy &
                      wave_done & (state_reg != DRAIN) & ~swap;
   assign accept    = cmd.valid & ready_int;
   assign cmd.ready = ready_int;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:  if (accept) state_next = LOAD;
         LOAD:  if (swap) state_next = RUN;
         RUN:   if (~stall_i & (rem_reg == '0) & ~shadow_ready & cur_last_reg)
                   state_next = DRAIN;
         DRAIN: if (~stall_i & (drain_cnt_reg == DRAIN_LAST))
                   state_next = (shadow_full_reg | load_busy) ? LOAD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= IDLE;
      else if (!stall_i) state_reg <= state_next;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rdy_en_reg        <= 1'b0;
         stall_reg         <= 1'b0;
         pend_len_reg      <= '0;
         pend_last_reg     <= 1'b0;
         cur_last_reg      <= 1'b0;
         rem_reg           <= '0;
         load_active_reg   <= 1'b0;
         load_cnt_reg      <= '0;
         ld_d_valid_reg    <= 1'b0;
         ld_d_cnt_reg      <= '0;
         shadow_full_reg   <= 1'b0;
         first_pending_reg <= 1'b0;
         sel_reg           <= '0;
         cmp_reg           <= 1'b0;
         cmp_last_reg      <= 1'b0;
         res_sr_reg        <= '0;
         last_sr_reg       <= '0;
         drain_cnt_reg     <= '0;
      end else begin
         rdy_en_reg <= 1'b1;
         stall_reg  <= stall_i;
         if (!stall_i) begin
            if (accept) begin
               pend_len_reg    <= cmd.len;
               pend_last_reg   <= cmd.last;
               load_active_reg <= 1'b1;
               load_cnt_reg    <= '0;
            end else if (load_active_reg) begin
               load_cnt_reg <= load_cnt_reg + CNT_W'(1);
               if (load_cnt_reg == LOAD_LAST) load_active_reg <= 1'b0;
            end
            ld_d_valid_reg <= load_active_reg;
            ld_d_cnt_reg   <= load_cnt_reg;

            if (swap) begin
               shadow_full_reg <= 1'b0;
               cur_last_reg    <= pend_last_reg;
            end else if (load_finish) begin
               shadow_full_reg <= 1'b1;
            end

            rem_reg           <= rem_eff - LEN_W'(act_rd);
            first_pending_reg <= (swap | first_pending_reg) & ~act_rd;
            // Row 0 flips on the first vector of a tile; each lower row follows a cycle later.
            sel_reg           <= {sel_reg[MUL_SIZE-2:0], sel_reg[0] ^ wave_start};

            cmp_reg       <= act_rd;
            cmp_last_reg  <= act_rd & act_last;
            res_sr_reg    <= {res_sr_reg[PIPE_LAT-2:0], cmp_reg};
            last_sr_reg   <= {last_sr_reg[PIPE_LAT-2:0], cmp_last_reg};
            drain_cnt_reg <= (state_reg == DRAIN) ? drain_cnt_reg + DRN_W'(1) : '0;
         end
      end
   end

   // Shadow load enters at the top row and shifts down, so row r is written from load cycle r on.
   generate
      for (genvar gi = 0; gi < MUL_SIZE; gi++) begin : g_row
         assign load_weights_o[MUL_SIZE-1-gi] =
            ld_d_valid_reg & ~stall_i & (ld_d_cnt_reg >= CNT_W'(gi));
         assign compute_weight_sel_o[MUL_SIZE-1-gi] = {MUL_SIZE{sel_reg[gi]}};
      end
   endgenerate

   assign weight_rd_o        = load_active_reg & ~stall_i;
   assign act_rd_o           = act_rd;
   assign compute_o          = cmp_reg & ~stall_i;
   assign load_activations_o = cmp_reg & ~stall_i;
   assign stall_o            = stall_reg;
   assign result_valid_o     = res_sr_reg[PIPE_LAT-1];
   assign tile_done_o        = last_sr_reg[PIPE_LAT-1];
   assign busy_o             = (state_reg != IDLE) | (|res_sr_reg);

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// Directed bench for systolic_array_ctrl: event logs are compared against
// hand-derived cycle offsets measured from each command's accept cycle.
module tb_systolic_array_ctrl;
   localparam int MS = 8;
   localparam int LW = 10;

   logic clk_i = 1'b0;
   logic rst_ni = 1'b0;
   logic act_rdy_i, stall_i;
   logic weight_rd_o, act_rd_o, compute_o, load_activations_o, stall_o;
   logic result_valid_o, tile_done_o, busy_o;
   logic [MS-1:0]         load_weights_o;
   logic [MS-1:0][MS-1:0] compute_weight_sel_o;

   systolic_array_ctrl_if #(.LEN_W(LW)) cmd_if ();

   systolic_array_ctrl #(.MUL_SIZE(MS), .LEN_W(LW), .PIPE_LAT(2*MS)) dut (
      .clk_i                (clk_i),
      .rst_ni               (rst_ni),
      .cmd                  (cmd_if),
      .weight_rd_o          (weight_rd_o),
      .act_rdy_i            (act_rdy_i),
      .act_rd_o             (act_rd_o),
      .stall_i              (stall_i),
      .load_weights_o       (load_weights_o),
      .compute_o            (compute_o),
      .load_activations_o   (load_activations_o),
      .stall_o              (stall_o),
      .compute_weight_sel_o (compute_weight_sel_o),
      .result_valid_o       (result_valid_o),
      .tile_done_o          (tile_done_o),
      .busy_o               (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int acc_q[$], wrd_q[$], r7_q[$], r0_q[$], cmp_q[$], res_q[$], done_q[$];
   int la_n = 0;
   int last_busy = 0;
   int last_flip[MS];
   logic [MS-1:0] prev_sel = '0;
   int b_acc, b_wrd, b_r7, b_r0, b_cmp, b_res, b_done, b_la;
   int acc;

   always @(posedge clk_i) cyc <= cyc + 1;

   always @(negedge clk_i) begin
      if (cmd_if.valid && cmd_if.ready) acc_q.push_back(cyc);
      if (weight_rd_o) wrd_q.push_back(cyc);
      if (load_weights_o[0]) r7_q.push_back(cyc);
      if (load_weights_o[MS-1]) r0_q.push_back(cyc);
      if (compute_o) cmp_q.push_back(cyc);
      if (load_activations_o) la_n++;
      if (result_valid_o) res_q.push_back(cyc);
      if (tile_done_o) done_q.push_back(cyc);
      if (busy_o) last_busy = cyc;
      for (int r = 0; r < MS; r++) begin
         if (compute_weight_sel_o[MS-1-r][0] !== prev_sel[r]) last_flip[r] = cyc;
         prev_sel[r] = compute_weight_sel_o[MS-1-r][0];
      end
   end

   function automatic int qat(input int q[$], input int i);
      return (i < q.size()) ? q[i] : -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #2;
   endtask

   task automatic snap();
      b_acc = acc_q.size();  b_wrd = wrd_q.size(); b_r7 = r7_q.size();
      b_r0 = r0_q.size();    b_cmp = cmp_q.size(); b_res = res_q.size();
      b_done = done_q.size(); b_la = la_n;
   endtask

   task automatic send(input int len, input bit last);
      bit got = 1'b0;
      cmd_if.valid = 1'b1;
      cmd_if.len   = LW'(len);
      cmd_if.last  = last;
      #1;
      for (int i = 0; i < 300 && !got; i++) begin
         if (cmd_if.ready) got = 1'b1;
         else tick();
      end
      tick();
      cmd_if.valid = 1'b0;
      chk("cmd_accept", got, 1);
      $display("cmd len=%0d last=%0d accepted=%0d at cycle %0d", len, last, got, cyc - 1);
   endtask

   task automatic wait_idle(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (!busy_o) break;
      end
      chk("idle_reached", busy_o, 0);
   endtask

   task automatic wait_compute(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         tick();
         if (compute_o) seen = 1'b1;
      end
      chk("compute_seen", seen, 1);
   endtask

   initial begin
      cmd_if.valid = 1'b0;
      cmd_if.len   = '0;
      cmd_if.last  = 1'b0;
      act_rdy_i    = 1'b1;
      stall_i      = 1'b0;
      repeat (3) tick();

      // reset state
      chk("rst_ready", cmd_if.ready, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_weight_rd", weight_rd_o, 0);
      chk("rst_act_rd", act_rd_o, 0);
      chk("rst_compute", compute_o, 0);
      chk("rst_load_w", load_weights_o, 0);
      chk("rst_sel", compute_weight_sel_o, 0);
      chk("rst_result", result_valid_o, 0);
      chk("rst_done", tile_done_o, 0);
      chk("rst_stall_o", stall_o, 0);
      rst_ni = 1'b1;
      repeat (2) tick();
      chk("ready_after_reset", cmd_if.ready, 1);

      // single tile, len=4, last
      snap();
      send(4, 1);
      wait_idle(200);
      acc = qat(acc_q, b_acc);
      chk("t1_wrd_count", wrd_q.size() - b_wrd, 8);
      chk("t1_wrd_first", qat(wrd_q, b_wrd), acc + 1);
      chk("t1_row7_count", r7_q.size() - b_r7, 1);
      chk("t1_row7_cycle", qat(r7_q, b_r7), acc + 9);
      chk("t1_row0_count", r0_q.size() - b_r0, 8);
      chk("t1_row0_first", qat(r0_q, b_r0), acc + 2);
      chk("t1_cmp_count", cmp_q.size() - b_cmp, 4);
      chk("t1_cmp_first", qat(cmp_q, b_cmp), acc + 10);
      chk("t1_cmp_last", qat(cmp_q, b_cmp + 3), acc + 13);
      chk("t1_la_count", la_n - b_la, 4);
      chk("t1_res_count", res_q.size() - b_res, 4);
      chk("t1_res_first", qat(res_q, b_res), acc + 26);
      chk("t1_done_count", done_q.size() - b_done, 1);
      chk("t1_done_cycle", qat(done_q, b_done), acc + 29);
      chk("t1_busy_last", last_busy, acc + 29);
      chk("t1_ready_idle", cmd_if.ready, 1);

      // two back-to-back tiles of 20, second accepted while the first runs
      snap();
      send(20, 0);
      send(20, 1);
      wait_idle(300);
      acc = qat(acc_q, b_acc);
      chk("t2_second_accept", qat(acc_q, b_acc + 1), acc + 17);
      chk("t2_cmp_count", cmp_q.size() - b_cmp, 40);
      chk("t2_tileA_last", qat(cmp_q, b_cmp + 19), acc + 29);
      chk("t2_tileB_first", qat(cmp_q, b_cmp + 20), acc + 30);
      chk("t2_done_count", done_q.size() - b_done, 2);
      chk("t2_doneA", qat(done_q, b_done), acc + 45);
      chk("t2_doneB", qat(done_q, b_done + 1), acc + 65);
      for (int r = 0; r < MS; r++)
         chk($sformatf("t2_flip_row%0d", r), last_flip[r], acc + 30 + r);

      // act_rdy toggling every cycle during a len=4 tile
      snap();
      send(4, 1);
      for (int i = 0; i < 200; i++) begin
         tick();
         act_rdy_i = ~act_rdy_i;
         #1;
         if (!busy_o) break;
      end
      act_rdy_i = 1'b1;
      chk("t3_idle", busy_o, 0);
      chk("t3_cmp_count", cmp_q.size() - b_cmp, 4);
      chk("t3_cmp_gap", qat(cmp_q, b_cmp + 1) - qat(cmp_q, b_cmp), 2);
      chk("t3_cmp_span", qat(cmp_q, b_cmp + 3) - qat(cmp_q, b_cmp), 6);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t3_res_lat%0d", i), qat(res_q, b_res + i) - qat(cmp_q, b_cmp + i), 16);
      chk("t3_done", qat(done_q, b_done), qat(res_q, b_res + 3));

      // 5-cycle stall mid-load and again mid-RUN
      snap();
      send(4, 1);
      repeat (2) tick();
      stall_i = 1'b1;
      tick();
      chk("t4_wrd_stalled", weight_rd_o, 0);
      chk("t4_stall_o", stall_o, 1);
      repeat (4) tick();
      stall_i = 1'b0;
      wait_compute(100);
      tick();
      stall_i = 1'b1;
      #1;
      chk("t4_cmp_stalled", compute_o, 0);
      repeat (5) tick();
      stall_i = 1'b0;
      wait_idle(200);
      acc = qat(acc_q, b_acc);
      chk("t4_wrd_count", wrd_q.size() - b_wrd, 8);
      chk("t4_row7_cycle", qat(r7_q, b_r7), acc + 14);
      chk("t4_cmp_count", cmp_q.size() - b_cmp, 4);
      chk("t4_cmp_first", qat(cmp_q, b_cmp), acc + 15);
      chk("t4_cmp_second", qat(cmp_q, b_cmp + 1), acc + 21);
      chk("t4_res_count", res_q.size() - b_res, 4);
      chk("t4_done_cycle", qat(done_q, b_done), acc + 39);
      chk("t4_busy_last", last_busy, acc + 39);

      // zero length behaves as one vector
      snap();
      send(0, 1);
      wait_idle(200);
      acc = qat(acc_q, b_acc);
      chk("t5_cmp_count", cmp_q.size() - b_cmp, 1);
      chk("t5_cmp_cycle", qat(cmp_q, b_cmp), acc + 10);
      chk("t5_res_count", res_q.size() - b_res, 1);
      chk("t5_done_cycle", qat(done_q, b_done), acc + 26);
      chk("t5_busy_last", last_busy, acc + 26);

      // asynchronous reset in the middle of a tile
      send(20, 1);
      wait_compute(100);
      repeat (3) tick();
      rst_ni = 1'b0;
      #1;
      chk("t6_busy", busy_o, 0);
      chk("t6_compute", compute_o, 0);
      chk("t6_act_rd", act_rd_o, 0);
      chk("t6_weight_rd", weight_rd_o, 0);
      chk("t6_sel", compute_weight_sel_o, 0);
      chk("t6_result", result_valid_o, 0);
      chk("t6_ready", cmd_if.ready, 0);
      repeat (2) tick();
      rst_ni = 1'b1;
      repeat (2) tick();
      chk("t6_ready_after", cmd_if.ready, 1);
      chk("t6_busy_after", busy_o, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
